// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : instr_mem_loader
// Packs a byte stream MSB-first into 32-bit words and writes each to imem.
// Rev    : 1.0
// ============================================================================
module instr_mem_loader #(
  parameter int          DEPTH     = 512,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter int          CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic [7:0]       RxData,
  input  logic             RxValid,
  output logic             RxReady,
  output logic             WrEn,
  output logic [31:0]      WrAddr,
  output logic [31:0]      WrData,
  output logic             Loading,
  output logic             Done,
  output logic [CNT_W-1:0] WordCount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [23:0]      r_shift;
  logic [1:0]       r_bcnt;
  logic [CNT_W-1:0] r_widx;
  logic [CNT_W-1:0] r_wcount;
  logic [31:0]      r_wrdata;

  logic             w_accept;
  logic             w_last_byte;
  logic             w_start;
  logic             w_stop;
  logic [CNT_W-1:0] w_wcount_inc;

  assign w_accept     = RxValid && RxReady;
  assign w_last_byte  = w_accept && (r_bcnt == 2'd3);
  assign w_start      = Start && !Abort;
  assign w_wcount_inc = r_wcount + c_one;
  assign w_stop       = (r_wrdata == HALT_WORD) || (w_wcount_inc == c_depth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (Start)       w_next_state = S_COLLECT;
      S_COLLECT:      if (w_last_byte) w_next_state = S_WRITE;
      S_WRITE:        w_next_state = w_stop ? S_DONE : S_COLLECT;
      default:        w_next_state = S_IDLE;
    endcase
    // Abort overrides every transition, including a simultaneous Start.
    if (Abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bcnt   <= '0;
      r_widx   <= '0;
      r_wcount <= '0;
      r_wrdata <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_widx   <= '0;
            r_wcount <= '0;
            r_bcnt   <= '0;
            r_shift  <= '0;
          end
        end
        S_COLLECT: begin
          if (Abort) begin
            r_bcnt  <= '0;
            r_shift <= '0;
          end else if (w_accept) begin
            r_shift <= {r_shift[15:0], RxData};
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_wrdata <= {r_shift, RxData};
          end
        end
        S_WRITE: begin
          // The write in flight always counts; the address only advances if another word follows.
          r_wcount <= w_wcount_inc;
          if (!Abort && !w_stop) r_widx <= r_widx + c_one;
        end
        default: ;
      endcase
    end
  end

  assign RxReady   = (r_state == S_COLLECT);
  assign WrEn      = (r_state == S_WRITE);
  assign Loading   = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign Done      = (r_state == S_DONE);
  assign WrAddr    = {{(30-CNT_W){1'b0}}, r_widx, 2'b00};
  assign WrData    = r_wrdata;
  assign WordCount = r_wcount;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_mem_loader
// Self-checking bench: vector table, directed corner cases, random sessions.
// Rev    : 1.0
// ============================================================================
module tb_instr_mem_loader;

  localparam int          DEPTH = 512;
  localparam int          CNT_W = 10;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic [7:0]       RxData = 8'h00;
  logic             RxValid = 1'b0;
  logic             RxReady;
  logic             WrEn;
  logic [31:0]      WrAddr;
  logic [31:0]      WrData;
  logic             Loading;
  logic             Done;
  logic [CNT_W-1:0] WordCount;

  instr_mem_loader #(.DEPTH(DEPTH), .HALT_WORD(HALT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Loading(Loading), .Done(Done), .WordCount(WordCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rx_dead = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] data;
    logic [31:0] addr;
    int          cnt;
    bit          done;
  } vec_t;
  vec_t vecs[3];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: every write must match the scoreboard and land one cycle after a 4th accepted byte.
  int  mon_bc  = 0;
  bit  mon_due = 1'b0;
  wr_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bc  = 0;
      mon_due = 1'b0;
    end else begin
      if (WrEn || mon_due) check("wren_timing", 32'(WrEn), 32'(mon_due));
      if (WrEn) begin
        if (exp_q.size() == 0) begin
          check("wren_expected", 32'(exp_q.size() != 0), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", WrAddr, mon_e.addr);
          check("wr_data", WrData, mon_e.data);
        end
      end
      mon_due = 1'b0;
      if (RxValid && RxReady && !Abort) begin
        mon_bc++;
        if (mon_bc == 4) begin
          mon_bc  = 0;
          mon_due = 1'b1;
        end
      end
      if (Abort) mon_bc = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_abort);
    Start = 1'b1;
    Abort = with_abort;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  task automatic do_abort();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int to;
    int limit;
    limit   = rx_dead ? 2 : 100;
    RxValid = 1'b0;
    repeat (gap) tick();
    RxValid = 1'b1;
    RxData  = b;
    to      = 0;
    @(negedge clk);
    while (!RxReady && to < limit) begin
      to++;
      @(negedge clk);
    end
    if (!RxReady) rx_dead = 1'b1;
    check("rx_handshake", 32'(RxReady), 32'd1);
    tick();
    RxValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], $urandom_range(gapmax, 0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxready"}, 32'(RxReady), 32'd0);
    check({tag, "_wren"}, 32'(WrEn), 32'd0);
    check({tag, "_loading"}, 32'(Loading), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_wraddr"}, WrAddr, 32'd0);
    check({tag, "_wrdata"}, WrData, 32'd0);
    check({tag, "_count"}, 32'(WordCount), 32'd0);
  endtask

  logic [31:0] words[8];
  int          n, k, full;
  bit          halted;

  initial begin
    vecs[0] = '{8'h00, 8'h85, 8'h88, 8'h20, 32'h00858820, 32'h0, 1, 1'b0};
    vecs[1] = '{8'h8E, 8'h64, 8'h00, 8'h14, 32'h8E640014, 32'h4, 2, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 32'h8, 3, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic load from the vector table.
    pulse_start(1'b0);
    check("start_loading", 32'(Loading), 32'd1);
    for (int i = 0; i < 3; i++) begin
      push_exp(vecs[i].addr, vecs[i].data);
      send_byte(vecs[i].b0, 0);
      send_byte(vecs[i].b1, 0);
      send_byte(vecs[i].b2, 0);
      send_byte(vecs[i].b3, 0);
      check("tbl_wren", 32'(WrEn), 32'd1);
      check("tbl_addr", WrAddr, vecs[i].addr);
      check("tbl_data", WrData, vecs[i].data);
      check("tbl_rxready_write", 32'(RxReady), 32'd0);
      tick();
      check("tbl_wren_off", 32'(WrEn), 32'd0);
      check("tbl_count", 32'(WordCount), 32'(vecs[i].cnt));
      check("tbl_done", 32'(Done), 32'(vecs[i].done));
    end

    // Start and Abort together in DONE: Abort wins, counters retained.
    pulse_start(1'b1);
    check("sa_done", 32'(Done), 32'd0);
    check("sa_loading", 32'(Loading), 32'd0);
    check("sa_count", 32'(WordCount), 32'd3);
    check("sa_addr", WrAddr, 32'h8);
    repeat (3) tick();
    check("sa_idle_hold", 32'(Loading), 32'd0);

    // One word with random RxValid gaps.
    pulse_start(1'b0);
    check("gap_count0", 32'(WordCount), 32'd0);
    check("gap_addr0", WrAddr, 32'd0);
    push_exp(32'h0, 32'h10430018);
    send_word(32'h10430018, 4);
    tick();
    check("gap_count", 32'(WordCount), 32'd1);
    check("gap_addr", WrAddr, 32'h4);
    check("gap_loading", 32'(Loading), 32'd1);
    repeat (5) tick();
    do_abort();
    check("gap_abort_loading", 32'(Loading), 32'd0);
    check("gap_abort_count", 32'(WordCount), 32'd1);
    check("gap_abort_addr", WrAddr, 32'h4);

    // Abort mid-word, with a byte handshake on the same edge.
    pulse_start(1'b0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    RxValid = 1'b1;
    RxData  = 8'hCC;
    Abort   = 1'b1;
    tick();
    RxValid = 1'b0;
    Abort   = 1'b0;
    check("abort_loading", 32'(Loading), 32'd0);
    check("abort_rxready", 32'(RxReady), 32'd0);
    repeat (3) tick();
    pulse_start(1'b0);
    push_exp(32'h0, 32'h01020304);
    send_word(32'h01020304, 0);
    tick();
    check("abort_next_count", 32'(WordCount), 32'd1);
    do_abort();

    // Asynchronous reset mid-session.
    pulse_start(1'b0);
    push_exp(32'h0, 32'h11223344);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    pulse_start(1'b0);
    push_exp(32'h0, 32'hA1B2C3D4);
    send_word(32'hA1B2C3D4, 1);
    tick();
    check("post_rst_count", 32'(WordCount), 32'd1);
    check("post_rst_addr", WrAddr, 32'h4);
    do_abort();

    // Random sessions against a word-level model.
    for (int s = 0; s < 6; s++) begin
      n      = $urandom_range(6, 1);
      halted = (s % 2 == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      for (int w = 0; w < n; w++) begin
        words[w] = $urandom;
        if (words[w] == HALT) words[w] = 32'h0;
      end
      if (halted) words[n-1] = HALT;
      k    = (s % 3 == 2) ? 4 * $urandom_range(n - 1, 0) + $urandom_range(3, 1) : 4 * n;
      full = k / 4;
      pulse_start(1'b0);
      check("rand_start_count", 32'(WordCount), 32'd0);
      check("rand_start_done", 32'(Done), 32'd0);
      for (int w = 0; w < full; w++) push_exp(32'(4 * w), words[w]);
      for (int j = 0; j < k; j++) send_byte(words[j/4][31-8*(j%4) -: 8], $urandom_range(2, 0));
      if (k < 4 * n) begin
        do_abort();
        check("rand_ab_loading", 32'(Loading), 32'd0);
        check("rand_ab_done", 32'(Done), 32'd0);
        check("rand_ab_count", 32'(WordCount), 32'(full));
        check("rand_ab_addr", WrAddr, 32'(4 * full));
      end else begin
        tick();
        check("rand_count", 32'(WordCount), 32'(n));
        check("rand_done", 32'(Done), 32'(halted));
        check("rand_loading", 32'(Loading), 32'(!halted));
        check("rand_addr", WrAddr, halted ? 32'(4 * (n - 1)) : 32'(4 * n));
        if (!halted) do_abort();
      end
      check("rand_drain", 32'(exp_q.size()), 32'd0);
    end

    // Memory-full stop after DEPTH non-halt words.
    pulse_start(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      push_exp(32'(4 * i), 32'(i));
      send_word(32'(i), 0);
    end
    tick();
    check("full_done", 32'(Done), 32'd1);
    check("full_loading", 32'(Loading), 32'd0);
    check("full_count", 32'(WordCount), 32'(DEPTH));
    check("full_addr", WrAddr, 32'h7FC);
    RxValid = 1'b1;
    RxData  = 8'h5A;
    repeat (8) begin
      @(negedge clk);
      check("full_rxready", 32'(RxReady), 32'd0);
    end
    tick();
    RxValid = 1'b0;
    check("full_count_hold", 32'(WordCount), 32'(DEPTH));
    check("full_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
